chime_seq: RTL and testbench

CHIME_SEQ -- requirements
Module: chime_seq

---
 rtl/chime_seq.sv | 182 ++++++++++++++++++
 tb/tb_chime_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/chime_seq.sv
// chime_seq: walking one-hot chime sequencer with a companion blink pattern.
// After a start request the block runs REPEATS passes of a one-hot pattern.
// Each pattern is held for DIV cycles. blink inverts at every step.
// Optional feature: define CHIME_SEQ_ABORT_EN to add the abort input.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst    : asynchronous active-high reset
//   abort  : (CHIME_SEQ_ABORT_EN only) cancels a running sequence
//   start  : level-sampled start request, honoured only in IDLE
//   mode   : 0 shift right, 1 shift left, 2 bounce, 3 treated as 0
//   walk   : one-hot walking pattern
//   blink  : all-bits-equal toggle pattern
//   busy   : high while the sequence runs
//   done   : one-cycle pulse when the sequence completes
module chime_seq #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned REPEATS = 1,
   parameter int unsigned DIV     = 1
) (
   input  logic             clk,
   input  logic             rst,
`ifdef CHIME_SEQ_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] walk,
   output logic [WIDTH-1:0] blink,
   output logic             busy,
   output logic             done
);

   localparam int unsigned HW = $clog2(DIV + 1);
   localparam int unsigned PW = 8;
   localparam logic [WIDTH-1:0] MSB_PAT = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [HW-1:0]    HOLD_LAST = HW'(DIV - 1);
   localparam logic [PW:0]      REP_LIM = (PW+1)'(REPEATS);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] walk_nxt, blink_nxt, step_pat;
   logic             busy_nxt, done_nxt;
   logic [HW-1:0]    hold_cnt, hold_nxt;
   logic [PW-1:0]    pass_cnt, pass_nxt;
   logic [1:0]       mode_q, mode_nxt, mode_norm;
   logic             dir_up, dir_nxt, step_dir;
   logic             pass_end, abort_hit;

`ifdef CHIME_SEQ_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   // Reserved mode 3 folds onto mode 0 at capture time.
   assign mode_norm = (mode == 2'd3) ? 2'd0 : mode;

   function automatic logic [WIDTH-1:0] init_pat(input logic [1:0] m);
      return (m == 2'd1) ? WIDTH'(1) : MSB_PAT;
   endfunction

   // Pattern that would follow the current one, and bounce direction after it.
   always_comb begin
      step_pat = '0;
      step_dir = dir_up;
      case (mode_q)
         2'd1: step_pat = walk << 1;
         2'd2: begin
            if (dir_up) begin
               step_pat = walk << 1;
            end else if (walk[0]) begin
               step_pat = walk << 1;
               step_dir = 1'b1;
            end else begin
               step_pat = walk >> 1;
            end
         end
         default: step_pat = walk >> 1;
      endcase
   end

   // Shift passes end on the all-zero pattern; a bounce pass ends just before
   // it would revisit the MSB.
   assign pass_end = (mode_q == 2'd2) ? (step_pat == MSB_PAT) : (walk == '0);

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt = state;
      walk_nxt  = walk;
      blink_nxt = blink;
      hold_nxt  = hold_cnt;
      pass_nxt  = pass_cnt;
      mode_nxt  = mode_q;
      dir_nxt   = dir_up;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            walk_nxt  = '0;
            blink_nxt = '0;
            hold_nxt  = '0;
            pass_nxt  = '0;
            if (start) begin
               state_nxt = RUN;
               mode_nxt  = mode_norm;
               walk_nxt  = init_pat(mode_norm);
               dir_nxt   = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         RUN: begin
            busy_nxt = 1'b1;
            if (abort_hit) begin
               state_nxt = IDLE;
               walk_nxt  = '0;
               blink_nxt = '0;
               hold_nxt  = '0;
               pass_nxt  = '0;
               busy_nxt  = 1'b0;
            end else if (hold_cnt == HOLD_LAST) begin
               hold_nxt  = '0;
               blink_nxt = ~blink;
               if (!pass_end) begin
                  walk_nxt = step_pat;
                  dir_nxt  = step_dir;
               end else if (({1'b0, pass_cnt} + 9'd1) < REP_LIM) begin
                  walk_nxt = init_pat(mode_q);
                  dir_nxt  = 1'b0;
                  pass_nxt = pass_cnt + 8'd1;
               end else begin
                  state_nxt = FIN;
                  walk_nxt  = '0;
                  blink_nxt = '0;
                  pass_nxt  = '0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end
            end else begin
               hold_nxt = hold_cnt + HW'(1);
            end
         end
         FIN: begin
            state_nxt = IDLE;
            walk_nxt  = '0;
            blink_nxt = '0;
         end
         default: begin
            state_nxt = IDLE;
            walk_nxt  = '0;
            blink_nxt = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         walk     <= '0;
         blink    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hold_cnt <= '0;
         pass_cnt <= '0;
         mode_q   <= 2'd0;
         dir_up   <= 1'b0;
      end else begin
         state    <= state_nxt;
         walk     <= walk_nxt;
         blink    <= blink_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         hold_cnt <= hold_nxt;
         pass_cnt <= pass_nxt;
         mode_q   <= mode_nxt;
         dir_up   <= dir_nxt;
      end
   end

endmodule

// File: tb/tb_chime_seq.sv
// Self-checking bench for chime_seq: table-driven vectors on a WIDTH=4,
// DIV=1, REPEATS=1 instance plus hand sequences for reset, abort and a
// WIDTH=4, DIV=2, REPEATS=2 bounce instance.
module tb_chime_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
   logic       abort_a = 1'b0, abort_b = 1'b0;
   logic [3:0] walk_a, blink_a, walk_b, blink_b;
   logic       busy_a, done_a, busy_b, done_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   chime_seq #(.WIDTH(4), .REPEATS(1), .DIV(1)) dut_a (
      .clk(clk), .rst(rst),
`ifdef CHIME_SEQ_ABORT_EN
      .abort(abort_a),
`endif
      .start(start_a), .mode(mode_a),
      .walk(walk_a), .blink(blink_a), .busy(busy_a), .done(done_a)
   );

   chime_seq #(.WIDTH(4), .REPEATS(2), .DIV(2)) dut_b (
      .clk(clk), .rst(rst),
`ifdef CHIME_SEQ_ABORT_EN
      .abort(abort_b),
`endif
      .start(start_b), .mode(mode_b),
      .walk(walk_b), .blink(blink_b), .busy(busy_b), .done(done_b)
   );

   typedef struct {
      logic       start;
      logic [1:0] mode;
      logic [3:0] walk;
      logic [3:0] blink;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int idx,
                        input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic [1:0] m, input logic [3:0] w,
                      input logic [3:0] b, input logic bu, input logic d);
      vec_t v;
      v.start = s; v.mode = m; v.walk = w; v.blink = b; v.busy = bu; v.done = d;
      vecs.push_back(v);
   endtask

   task automatic check_a(input string tag, input int idx, input logic [3:0] w,
                          input logic [3:0] b, input logic bu, input logic d);
      check({tag, ".walk"},  idx, 16'(walk_a),  16'(w));
      check({tag, ".blink"}, idx, 16'(blink_a), 16'(b));
      check({tag, ".busy"},  idx, 16'(busy_a),  16'(bu));
      check({tag, ".done"},  idx, 16'(done_a),  16'(d));
   endtask

   initial begin
      logic [3:0] bounce [12];
      int dones;
      bounce = '{4'h8, 4'h8, 4'h4, 4'h4, 4'h2, 4'h2, 4'h1, 4'h1,
                 4'h2, 4'h2, 4'h4, 4'h4};

      // mode 0 single pass; mode change and start during RUN / FIN ignored
      add(1, 0, 4'h8, 4'h0, 1, 0);
      add(0, 1, 4'h4, 4'hF, 1, 0);
      add(1, 1, 4'h2, 4'h0, 1, 0);
      add(0, 0, 4'h1, 4'hF, 1, 0);
      add(0, 0, 4'h0, 4'h0, 1, 0);
      add(0, 0, 4'h0, 4'h0, 0, 1);
      add(1, 0, 4'h0, 4'h0, 0, 0);
      // mode 1 single pass
      add(1, 1, 4'h1, 4'h0, 1, 0);
      add(0, 0, 4'h2, 4'hF, 1, 0);
      add(0, 0, 4'h4, 4'h0, 1, 0);
      add(0, 0, 4'h8, 4'hF, 1, 0);
      add(0, 0, 4'h0, 4'h0, 1, 0);
      add(0, 0, 4'h0, 4'h0, 0, 1);
      add(0, 0, 4'h0, 4'h0, 0, 0);
      // mode 2 single bounce pass, never walk=0 during RUN
      add(1, 2, 4'h8, 4'h0, 1, 0);
      add(0, 0, 4'h4, 4'hF, 1, 0);
      add(0, 0, 4'h2, 4'h0, 1, 0);
      add(0, 0, 4'h1, 4'hF, 1, 0);
      add(0, 0, 4'h2, 4'h0, 1, 0);
      add(0, 0, 4'h4, 4'hF, 1, 0);
      add(0, 0, 4'h0, 4'h0, 0, 1);
      add(0, 0, 4'h0, 4'h0, 0, 0);
      // reserved mode 3 behaves as mode 0; start held high retriggers
      add(1, 3, 4'h8, 4'h0, 1, 0);
      add(1, 0, 4'h4, 4'hF, 1, 0);
      add(1, 0, 4'h2, 4'h0, 1, 0);
      add(1, 0, 4'h1, 4'hF, 1, 0);
      add(1, 0, 4'h0, 4'h0, 1, 0);
      add(1, 0, 4'h0, 4'h0, 0, 1);
      add(1, 0, 4'h0, 4'h0, 0, 0);
      add(1, 0, 4'h8, 4'h0, 1, 0);
      add(1, 0, 4'h4, 4'hF, 1, 0);
      add(1, 0, 4'h2, 4'h0, 1, 0);

      // reset state
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_a("reset", 0, 4'h0, 4'h0, 0, 0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         start_a = vecs[i].start;
         mode_a  = vecs[i].mode;
         @(posedge clk);
         #1;
         check_a("vec", i, vecs[i].walk, vecs[i].blink, vecs[i].busy, vecs[i].done);
      end

      // asynchronous reset mid-run with start still high
      #2 rst = 1'b1;
      #1;
      check_a("rst_async", 0, 4'h0, 4'h0, 0, 0);
      @(posedge clk);
      #1;
      check_a("rst_prio", 0, 4'h0, 4'h0, 0, 0);
      start_a = 1'b0;
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done_a || busy_a) dones++;
      end
      check("rst_no_done", 0, 16'(dones), 16'd0);

`ifdef CHIME_SEQ_ABORT_EN
      start_a = 1'b1; mode_a = 2'd0;
      @(posedge clk); #1;
      check_a("abort_c1", 0, 4'h8, 4'h0, 1, 0);
      start_a = 1'b0;
      @(posedge clk); #1;
      check_a("abort_c2", 0, 4'h4, 4'hF, 1, 0);
      abort_a = 1'b1;
      @(posedge clk); #1;
      check_a("abort_idle", 0, 4'h0, 4'h0, 0, 0);
      abort_a = 1'b0;
      @(posedge clk); #1;
      check_a("abort_after", 0, 4'h0, 4'h0, 0, 0);
`endif

      // bounce with DIV=2, REPEATS=2; mode change mid-run ignored
      start_b = 1'b1; mode_b = 2'd2;
      @(posedge clk); #1;
      start_b = 1'b0; mode_b = 2'd1;
      for (int i = 0; i < 24; i++) begin
         check("b.walk",  i, 16'(walk_b),  16'(bounce[i % 12]));
         check("b.blink", i, 16'(blink_b), ((i / 2) % 2 != 0) ? 16'hF : 16'h0);
         check("b.busy",  i, 16'(busy_b),  16'd1);
         check("b.done",  i, 16'(done_b),  16'd0);
         @(posedge clk); #1;
      end
      check("b.fin_done", 24, 16'(done_b), 16'd1);
      check("b.fin_busy", 24, 16'(busy_b), 16'd0);
      check("b.fin_walk", 24, 16'(walk_b), 16'd0);
      @(posedge clk); #1;
      check("b.idle_done", 25, 16'(done_b), 16'd0);
      check("b.idle_busy", 25, 16'(busy_b), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
